// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types, default sizing and small helpers for the CDB arbiter slice.
// XLEN defaults to 32 unless the build predefines it.
`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

  localparam int XLEN_W    = `XLEN;
  localparam int NUM_FU    = 4;
  localparam int ROB_TAG_W = 5;
  localparam int CNT_W     = 16;

  localparam logic [CNT_W-1:0] GRANT_CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [XLEN_W-1:0]    v;
    logic                 take_branch;
    logic [XLEN_W-1:0]    branch_loc;
  } CDB_PACKET;

  // Perf counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == GRANT_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo N.
// Zero latency; no backpressure, the caller decides whether the grant is consumed.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld
);

  logic [PTR_W-1:0] w_idx;

  function automatic logic [PTR_W-1:0] wrap(input int unsigned a);
    int unsigned r;
    r = (a >= N) ? a - N : a;
    return r[PTR_W-1:0];
  endfunction

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = wrap(int'(i_ptr) + k);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational one-hot ack, registered broadcast one cycle later; squash flushes all held FUs.
// CDB_BRANCH_PRIORITY_EN: taken-branch results form a high-priority class arbitrated ahead of the rest.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
  parameter int TAG_W  = ROB_TAG_W
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_squash,
  input  logic [NUM_FU-1:0]        i_fu_done,
  input  logic [NUM_FU*TAG_W-1:0]  i_fu_rob_tag,
  input  logic [NUM_FU*XLEN_W-1:0] i_fu_value,
  input  logic [NUM_FU-1:0]        i_fu_take_branch,
  input  logic [NUM_FU*XLEN_W-1:0] i_fu_branch_loc,
  output logic [NUM_FU-1:0]        o_fu_ack,
  output logic                     o_cdb_valid,
  output logic [TAG_W-1:0]         o_cdb_rob_tag,
  output logic [XLEN_W-1:0]        o_cdb_value,
  output logic                     o_cdb_take_branch,
  output logic [XLEN_W-1:0]        o_cdb_branch_loc,
  output logic [CNT_W-1:0]         o_grant_count
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]  r_rr_ptr;
  CDB_PACKET         r_pkt;
  logic [CNT_W-1:0]  r_grant_count;

  logic [NUM_FU-1:0] w_norm_gnt;
  logic [PTR_W-1:0]  w_norm_idx;
  logic              w_norm_vld;
  logic [NUM_FU-1:0] w_gnt;
  logic [PTR_W-1:0]  w_win_idx;
  logic              w_gnt_vld;
  logic              w_grant;
  logic [PTR_W-1:0]  w_ptr_next;
  CDB_PACKET         w_pkt_next;

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr_norm (
    .i_req     (i_fu_done),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_norm_gnt),
    .o_gnt_idx (w_norm_idx),
    .o_gnt_vld (w_norm_vld)
  );

`ifdef CDB_BRANCH_PRIORITY_EN
  logic [NUM_FU-1:0] w_hp_req;
  logic [NUM_FU-1:0] w_hp_gnt;
  logic [PTR_W-1:0]  w_hp_idx;
  logic              w_hp_vld;

  assign w_hp_req = i_fu_done & i_fu_take_branch;

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr_hp (
    .i_req     (w_hp_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_hp_gnt),
    .o_gnt_idx (w_hp_idx),
    .o_gnt_vld (w_hp_vld)
  );

  // Both classes share one pointer, so the class switch never disturbs rotation.
  always_comb begin
    w_gnt     = w_norm_gnt;
    w_win_idx = w_norm_idx;
    w_gnt_vld = w_norm_vld;
    if (w_hp_vld) begin
      w_gnt     = w_hp_gnt;
      w_win_idx = w_hp_idx;
      w_gnt_vld = 1'b1;
    end
  end
`else
  assign w_gnt     = w_norm_gnt;
  assign w_win_idx = w_norm_idx;
  assign w_gnt_vld = w_norm_vld;
`endif

  // Under squash every held result is acked and dropped so the FUs drain in one edge.
  always_comb begin
    o_fu_ack = '0;
    if (i_reset) begin
      o_fu_ack = '0;
    end else if (i_squash) begin
      o_fu_ack = i_fu_done;
    end else begin
      o_fu_ack = w_gnt;
    end
  end

  assign w_grant    = w_gnt_vld && !i_squash;
  assign w_ptr_next = (int'(w_win_idx) == NUM_FU - 1) ? '0 : w_win_idx + 1'b1;

  always_comb begin
    w_pkt_next             = '0;
    w_pkt_next.valid       = 1'b1;
    w_pkt_next.rob_tag     = i_fu_rob_tag[int'(w_win_idx)*TAG_W +: TAG_W];
    w_pkt_next.v           = i_fu_value[int'(w_win_idx)*XLEN_W +: XLEN_W];
    w_pkt_next.take_branch = i_fu_take_branch[w_win_idx];
    w_pkt_next.branch_loc  = i_fu_branch_loc[int'(w_win_idx)*XLEN_W +: XLEN_W];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pkt         <= '0;
      r_rr_ptr      <= '0;
      r_grant_count <= '0;
    end else begin
      r_pkt.valid <= 1'b0;
      if (w_grant) begin
        r_pkt         <= w_pkt_next;
        r_rr_ptr      <= w_ptr_next;
        r_grant_count <= sat_inc(r_grant_count);
      end
    end
  end

  assign o_cdb_valid       = r_pkt.valid;
  assign o_cdb_rob_tag     = r_pkt.rob_tag;
  assign o_cdb_value       = r_pkt.v;
  assign o_cdb_take_branch = r_pkt.take_branch;
  assign o_cdb_branch_loc  = r_pkt.branch_loc;
  assign o_grant_count     = r_grant_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, rotation, sparse request, squash, branch class, counter saturation.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int TW = 5;
  localparam int XL = XLEN_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               squash;
  logic [NF-1:0]      fu_done;
  logic [NF*TW-1:0]   fu_rob_tag;
  logic [NF*XL-1:0]   fu_value;
  logic [NF-1:0]      fu_take_branch;
  logic [NF*XL-1:0]   fu_branch_loc;
  logic [NF-1:0]      fu_ack;
  logic               cdb_valid;
  logic [TW-1:0]      cdb_rob_tag;
  logic [XL-1:0]      cdb_value;
  logic               cdb_take_branch;
  logic [XL-1:0]      cdb_branch_loc;
  logic [15:0]        grant_count;

  int n_pass = 0;
  int n_chk  = 0;

  cdb_arbiter #(.NUM_FU(NF), .TAG_W(TW)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_squash          (squash),
    .i_fu_done         (fu_done),
    .i_fu_rob_tag      (fu_rob_tag),
    .i_fu_value        (fu_value),
    .i_fu_take_branch  (fu_take_branch),
    .i_fu_branch_loc   (fu_branch_loc),
    .o_fu_ack          (fu_ack),
    .o_cdb_valid       (cdb_valid),
    .o_cdb_rob_tag     (cdb_rob_tag),
    .o_cdb_value       (cdb_value),
    .o_cdb_take_branch (cdb_take_branch),
    .o_cdb_branch_loc  (cdb_branch_loc),
    .o_grant_count     (grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    squash         = 1'b0;
    fu_done        = '0;
    fu_take_branch = '0;
    fu_rob_tag     = '0;
    fu_value       = '0;
    fu_branch_loc  = '0;
    for (int i = 0; i < NF; i++) begin
      fu_rob_tag[i*TW +: TW]    = TW'(i + 1);
      fu_value[i*XL +: XL]      = XL'(32'hA0 + i);
      fu_branch_loc[i*XL +: XL] = XL'(32'hB0 + i);
    end
    tick();
    tick();

    // Reset state with every FU requesting
    fu_done = 4'b1111;
    #1;
    chk("rst_ack",   64'(fu_ack),      64'h0);
    chk("rst_valid", 64'(cdb_valid),   64'h0);
    chk("rst_tag",   64'(cdb_rob_tag), 64'h0);
    chk("rst_count", 64'(grant_count), 64'h0);

    rst = 1'b0;
    #1;
    chk("first_ack", 64'(fu_ack), 64'h1);

    // Rotation 1,2,3,4,1
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot_valid", 64'(cdb_valid),   64'h1);
      chk("rot_tag",   64'(cdb_rob_tag), 64'((k % 4) + 1));
    end
    chk("rot_count", 64'(grant_count), 64'd5);
    fu_done = '0;
    tick();
    chk("idle_valid", 64'(cdb_valid),   64'h0);
    chk("idle_count", 64'(grant_count), 64'd5);

    // Mid-stream async reset while a broadcast is live
    fu_done = 4'b1111;
    #1;
    chk("ptr1_ack", 64'(fu_ack), 64'h2);
    tick();
    chk("pre_rst_valid", 64'(cdb_valid),   64'h1);
    chk("pre_rst_tag",   64'(cdb_rob_tag), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(cdb_valid),   64'h0);
    chk("mid_rst_tag",   64'(cdb_rob_tag), 64'h0);
    chk("mid_rst_count", 64'(grant_count), 64'h0);
    chk("mid_rst_ack",   64'(fu_ack),      64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ack", 64'(fu_ack), 64'h1);
    tick();
    chk("post_rst_tag",   64'(cdb_rob_tag), 64'd1);
    chk("post_rst_count", 64'(grant_count), 64'd1);

    // Sparse single request from FU2
    fu_done = 4'b0100;
    #1;
    chk("sparse_ack", 64'(fu_ack), 64'h4);
    tick();
    chk("sparse_valid", 64'(cdb_valid),   64'h1);
    chk("sparse_tag",   64'(cdb_rob_tag), 64'd3);
    chk("sparse_value", 64'(cdb_value),   64'hA2);
    fu_done = '0;
    tick();
    chk("sparse_drop", 64'(cdb_valid),   64'h0);
    chk("sparse_cnt",  64'(grant_count), 64'd2);

    // Squash flushes all held results without broadcast or pointer move
    fu_done = 4'b1011;
    squash  = 1'b1;
    #1;
    chk("sq_ack", 64'(fu_ack), 64'hB);
    tick();
    chk("sq_valid", 64'(cdb_valid),   64'h0);
    chk("sq_count", 64'(grant_count), 64'd2);
    squash = 1'b0;
    #1;
    chk("sq_ptr_ack", 64'(fu_ack), 64'h8);
    tick();
    chk("sq_next_tag",   64'(cdb_rob_tag), 64'd4);
    chk("sq_next_count", 64'(grant_count), 64'd3);

    // Branch class: rr_ptr is 0, FU0 and FU3 request, FU3 has a taken branch
    fu_done           = 4'b1001;
    fu_take_branch[3] = 1'b1;
    #1;
`ifdef CDB_BRANCH_PRIORITY_EN
    chk("br_ack0", 64'(fu_ack), 64'h8);
    tick();
    chk("br_tag0", 64'(cdb_rob_tag),     64'd4);
    chk("br_tb0",  64'(cdb_take_branch), 64'h1);
    chk("br_loc0", 64'(cdb_branch_loc),  64'hB3);
    fu_done = 4'b0001;
    #1;
    chk("br_ack1", 64'(fu_ack), 64'h1);
    tick();
    chk("br_tag1", 64'(cdb_rob_tag),     64'd1);
    chk("br_tb1",  64'(cdb_take_branch), 64'h0);
`else
    chk("br_ack0", 64'(fu_ack), 64'h1);
    tick();
    chk("br_tag0", 64'(cdb_rob_tag),     64'd1);
    chk("br_tb0",  64'(cdb_take_branch), 64'h0);
    fu_done = 4'b1000;
    #1;
    chk("br_ack1", 64'(fu_ack), 64'h8);
    tick();
    chk("br_tag1", 64'(cdb_rob_tag),     64'd4);
    chk("br_tb1",  64'(cdb_take_branch), 64'h1);
    chk("br_loc1", 64'(cdb_branch_loc),  64'hB3);
`endif
    chk("br_count", 64'(grant_count), 64'd5);
    fu_done        = '0;
    fu_take_branch = '0;
    tick();

    // Counter saturation from a clean reset
    rst = 1'b1;
    #2;
    rst     = 1'b0;
    fu_done = 4'b1111;
    #1;
    chk("sat_start", 64'(grant_count), 64'h0);
    repeat (65534) tick();
    chk("sat_fffe", 64'(grant_count), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(grant_count), 64'hFFFF);
    tick();
    chk("sat_hold",  64'(grant_count), 64'hFFFF);
    chk("sat_valid", 64'(cdb_valid),   64'h1);
    fu_done = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between NUM_FU functional units that hold completed results until acknowledged. The ALU FUs are the primary requesters.
- Picks at most one ready FU per cycle with a rotating round-robin priority, returns a one-hot ack to the winner, and drives a registered CDB broadcast toward the ROB and reservation stations.
- Sits between the FU output registers and the ROB/RS CDB snoop ports.

Parameters:
- NUM_FU, 4, number of requesting FUs, range 2..8.
- TAG_W, 5, ROB tag width; must match ROB sizing.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- squash  in  1  pipeline flush from ROB, sampled on clock edge.
- fu_done  in  NUM_FU  per-FU "result held" flag.
- fu_rob_tag  in  NUM_FU*TAG_W  per-FU ROB tag; slice i is bits [i*TAG_W +: TAG_W].
- fu_value  in  NUM_FU*`XLEN  per-FU result value.
- fu_take_branch  in  NUM_FU  per-FU resolved branch-taken flag.
- fu_branch_loc  in  NUM_FU*`XLEN  per-FU branch target.
- fu_ack  out  NUM_FU  one-hot grant, combinational; the FU clears its output on the next edge.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_rob_tag  out  TAG_W  broadcast tag, registered.
- cdb_value  out  `XLEN  broadcast value, registered.
- cdb_take_branch  out  1  broadcast branch flag, registered.
- cdb_branch_loc  out  `XLEN  broadcast target, registered.
- grant_count  out  16  saturating count of CDB broadcasts, for perf and debug.

Behaviour:
- Reset (async): cdb_* = 0, rr_ptr = 0, grant_count = 0. fu_ack = 0 while reset is high.
- Arbitration (combinational):
  - Search fu_done starting at index rr_ptr, wrapping modulo NUM_FU.
  - The first set bit wins, and its fu_ack bit = 1.
  - If no bit is set, fu_ack = 0.
- Latency:
  - A request winning in cycle t appears on the cdb_* outputs after the edge ending cycle t; cdb_valid is high for exactly cycle t+1.
  - One grant per cycle maximum.
  - Throughput: one result per cycle while any fu_done is set.
- Pointer update at each edge with a grant and no squash: rr_ptr <= (winner+1) mod NUM_FU. With no grant, rr_ptr holds.
- Fairness: a continuously asserted fu_done is granted within NUM_FU cycles.
- Registered output on an edge with no grant: cdb_valid <= 0; the other cdb_* fields hold their old values and are don't-care.
- Squash, high at an edge:
  - fu_ack = fu_done during that cycle, so all held results are flushed.
  - cdb_valid <= 0 at that edge.
  - rr_ptr and grant_count unchanged; there is no broadcast for any FU acked under squash.
- Squash in the same cycle as cdb_valid = 1: the current broadcast completes, and the ROB discards it by its own squash.
- Counter: grant_count increments on each non-squash grant and saturates at 16'hFFFF, with no wrap.
- Reset asserted mid-stream: all outputs clear immediately (async), with no partial broadcast. The first grant after release starts the search at FU0.
- The arbiter assumes a requester holds fu_done and its payload stable until acked; it does not check this.

Optional Feature:
- Macro: CDB_BRANCH_PRIORITY_EN.
- Defined:
  - Requesters with fu_done && fu_take_branch form a high-priority class.
  - If that class is non-empty, round-robin runs over that class only. Otherwise round-robin runs over all of fu_done.
  - This lets mispredicts resolve sooner. The shared rr_ptr updates identically in both classes.
- Undefined: plain round-robin over fu_done; fu_take_branch only feeds cdb_take_branch.

Decomposition:
- sys_defs.svh:
  - `CDB_PACKET` typedef: valid, rob_tag, v, take_branch, branch_loc.
  - `NUM_FU` and `ROB_TAG_W` constants.
  - The registered cdb_* outputs are carried internally as one `CDB_PACKET` register.
- Sub-module `rr_arbiter`:
  - Purely combinational: parameter N; inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx.
  - Instantiated once, or twice under CDB_BRANCH_PRIORITY_EN (high-priority and normal class, result muxed).

Test Plan:
- Reset: assert reset mid-cycle with fu_done = 4'b1111 -> fu_ack = 0 immediately, cdb_valid = 0, grant_count = 0. After release, first grant goes to FU0.
- Rotation: fu_done held at 4'b1111 with distinct tags 1..4 -> cdb_rob_tag sequence 1,2,3,4,1 on consecutive cycles, cdb_valid continuously high, grant_count = 5.
- Sparse requests: fu_done = 4'b0100 for one cycle -> fu_ack = 4'b0100 that cycle, cdb_valid = 1 and cdb_value = FU2 value next cycle, then cdb_valid = 0.
- Squash: fu_done = 4'b1011 with squash = 1 -> fu_ack = 4'b1011, cdb_valid = 0 next cycle, grant_count and rr_ptr unchanged.
- Saturation: force grant_count to 16'hFFFE, then two grants -> 16'hFFFF, holds at 16'hFFFF on a third grant.
- Branch priority (macro defined): rr_ptr = 0, fu_done = 4'b1001, FU3 take_branch = 1 -> FU3 granted first, FU0 next cycle. With the macro undefined -> FU0 first, then FU3.
